// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative write-back cache.
// No logic: state codes, width helpers and default geometry only.
package cache_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESP   = 2'd1;
    localparam logic [1:0] ST_WB     = 2'd2;
    localparam logic [1:0] ST_REFILL = 2'd3;

    localparam int DEF_WAYS   = 4;
    localparam int DEF_SETS   = 4;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_DATA_W = 3;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int age_w(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_sa_wb_if.sv
// Requester and memory-side signal bundle of the cache.
// master = requester/memory harness, slave = cache.
interface cache_sa_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_hit, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_hit, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_lru.sv
// True-LRU helper for one set: picks the victim way and computes post-access ages.
// Purely combinational, zero latency, no backpressure.
module cache_lru #(
    parameter int WAYS  = 4,
    parameter int AGE_W = 2
) (
    input  logic [WAYS-1:0][AGE_W-1:0] age_i,
    input  logic [WAYS-1:0]            valid_i,
    input  logic [AGE_W-1:0]           acc_way_i,
    output logic [AGE_W-1:0]           victim_o,
    output logic [WAYS-1:0][AGE_W-1:0] age_o
);
    logic             found;
    logic [AGE_W-1:0] old_age;

    always_comb begin
        found    = 1'b0;
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                found    = 1'b1;
                victim_o = AGE_W'(w);
            end
        end
        // With every way valid, the oldest line is the one whose age is WAYS-1.
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_i[w] == AGE_W'(WAYS - 1)) begin
                    victim_o = AGE_W'(w);
                end
            end
        end
    end

    always_comb begin
        old_age = age_i[acc_way_i];
        age_o   = age_i;
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == acc_way_i) begin
                age_o[w] = '0;
            end else if (age_i[w] < old_age) begin
                age_o[w] = age_i[w] + AGE_W'(1);
            end
        end
    end
endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back/write-allocate cache, true LRU; CACHE_STATS_EN adds hit/miss counters.
// Hit: response 1 cycle after accept; miss: blocks in WRITEBACK/REFILL until mem_ack, req_ready low outside IDLE.
module cache_sa_wb
    import cache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int SETS   = DEF_SETS,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clock,
    input  logic        reset_n,
`ifdef CACHE_STATS_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    cache_sa_wb_if.slave bus
);
    localparam int IDX_W  = idx_w(SETS);
    localparam int AGE_W  = age_w(WAYS);
    localparam int ADDR_W = TAG_W + IDX_W;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0]             dirty_q [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
    logic [WAYS-1:0][DATA_W-1:0] data_q  [SETS];
    ages_t                       age_q   [SETS];

    logic [1:0]        state_q, state_d;
    logic              rdy_q;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [AGE_W-1:0]  vic_way_q, vic_way_d;
    logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
    logic [DATA_W-1:0] vic_dat_q, vic_dat_d;
    logic              resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0] resp_dat_q, resp_dat_d;

    logic [IDX_W-1:0]  in_idx, lat_idx, lru_idx;
    logic [TAG_W-1:0]  in_tag, lat_tag;
    logic              accept;
    logic              hit;
    logic [AGE_W-1:0]  hit_way, lru_acc, lru_victim;
    ages_t             lru_age;

    logic              line_we;
    logic [IDX_W-1:0]  line_idx;
    logic [AGE_W-1:0]  line_way;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_dat;
    logic              line_dirty;

    assign in_idx  = bus.req_addr[IDX_W-1:0];
    assign in_tag  = bus.req_addr[ADDR_W-1:IDX_W];
    assign lat_idx = req_addr_q[IDX_W-1:0];
    assign lat_tag = req_addr_q[ADDR_W-1:IDX_W];
    assign accept  = bus.req_valid && bus.req_ready;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[in_idx][w] && (tag_q[in_idx][w] == in_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // One LRU instance serves both the lookup set (IDLE) and the refill set.
    assign lru_idx = (state_q == ST_IDLE) ? in_idx  : lat_idx;
    assign lru_acc = (state_q == ST_IDLE) ? hit_way : vic_way_q;

    cache_lru #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .age_i     (age_q[lru_idx]),
        .valid_i   (valid_q[lru_idx]),
        .acc_way_i (lru_acc),
        .victim_o  (lru_victim),
        .age_o     (lru_age)
    );

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        vic_way_d   = vic_way_q;
        vic_tag_d   = vic_tag_q;
        vic_dat_d   = vic_dat_q;
        resp_hit_d  = resp_hit_q;
        resp_dat_d  = resp_dat_q;
        line_we     = 1'b0;
        line_idx    = in_idx;
        line_way    = hit_way;
        line_tag    = in_tag;
        line_dat    = data_q[in_idx][hit_way];
        line_dirty  = dirty_q[in_idx][hit_way];
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_write_d = bus.req_write;
                    req_addr_d  = bus.req_addr;
                    req_wdata_d = bus.req_wdata;
                    if (hit) begin
                        line_we    = 1'b1;
                        line_dat   = bus.req_write ? bus.req_wdata : data_q[in_idx][hit_way];
                        line_dirty = dirty_q[in_idx][hit_way] | bus.req_write;
                        resp_hit_d = 1'b1;
                        resp_dat_d = line_dat;
                        state_d    = ST_RESP;
                    end else begin
                        vic_way_d = lru_victim;
                        vic_tag_d = tag_q[in_idx][lru_victim];
                        vic_dat_d = data_q[in_idx][lru_victim];
                        state_d   = (valid_q[in_idx][lru_victim] && dirty_q[in_idx][lru_victim])
                                    ? ST_WB : ST_REFILL;
                    end
                end
            end
            ST_WB: begin
                if (bus.mem_ack) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (bus.mem_ack) begin
                    line_we    = 1'b1;
                    line_idx   = lat_idx;
                    line_way   = vic_way_q;
                    line_tag   = lat_tag;
                    line_dat   = req_write_q ? req_wdata_q : bus.mem_rdata;
                    line_dirty = req_write_q;
                    resp_hit_d = 1'b0;
                    resp_dat_d = line_dat;
                    state_d    = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            vic_way_q   <= '0;
            vic_tag_q   <= '0;
            vic_dat_q   <= '0;
            resp_hit_q  <= 1'b0;
            resp_dat_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            vic_way_q   <= vic_way_d;
            vic_tag_q   <= vic_tag_d;
            vic_dat_q   <= vic_dat_d;
            resp_hit_q  <= resp_hit_d;
            resp_dat_q  <= resp_dat_d;
        end
    end

    // Age of way w starts at w, so the initial ages already form a permutation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                tag_q[s]   <= '0;
                data_q[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (line_we) begin
            valid_q[line_idx][line_way] <= 1'b1;
            dirty_q[line_idx][line_way] <= line_dirty;
            tag_q[line_idx][line_way]   <= line_tag;
            data_q[line_idx][line_way]  <= line_dat;
            age_q[line_idx]             <= lru_age;
        end
    end

    assign bus.req_ready  = rdy_q && (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_rdata = resp_dat_q;
    assign bus.mem_req    = (state_q == ST_WB) || (state_q == ST_REFILL);
    assign bus.mem_we     = (state_q == ST_WB);
    assign bus.mem_addr   = (state_q == ST_WB)     ? {vic_tag_q, lat_idx} :
                            (state_q == ST_REFILL) ? req_addr_q : '0;
    assign bus.mem_wdata  = (state_q == ST_WB) ? vic_dat_q : '0;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (resp_hit_q && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!resp_hit_q && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_sa_wb.sv
// Randomised bench for cache_sa_wb against a recency-list cache model and a flat backing memory.
// Directed sequences cover reset, fill/LRU eviction, dirty writeback and reset during refill.
module tb_cache_sa_wb;
    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_err;

    cache_sa_wb_if #(.ADDR_W(5), .DATA_W(3)) bus ();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_sa_wb #(
        .WAYS   (4),
        .SETS   (4),
        .TAG_W  (3),
        .DATA_W (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
`ifdef CACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: per-set recency list (front = most recent) plus line contents.
    logic       mv   [4][4];
    logic       md   [4][4];
    logic [2:0] mt   [4][4];
    logic [2:0] mdat [4][4];
    int         ord  [4][$];
    logic [2:0] mem  [32];
    int         m_hits, m_miss;
    logic [4:0] last_wb_addr;
    logic [2:0] last_wb_dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            ord[s].delete();
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                ord[s].push_back(w);
            end
        end
    endtask

    task automatic touch(input int s, input int w);
        for (int i = 0; i < ord[s].size(); i++) begin
            if (ord[s][i] == w) begin
                ord[s].delete(i);
                break;
            end
        end
        ord[s].push_front(w);
    endtask

    function automatic int lookup(input logic [4:0] addr);
        int hw;
        hw = -1;
        for (int w = 0; w < 4; w++) begin
            if (hw < 0 && mv[addr[1:0]][w] && mt[addr[1:0]][w] == addr[4:2]) hw = w;
        end
        return hw;
    endfunction

    task automatic serve(input logic [2:0] rd);
        logic [9:0] snap;
        snap = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        repeat ($urandom_range(0, 3)) begin
            @(posedge clock);
            @(negedge clock);
            chk("mem_hold", {22'd0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {22'd0, snap});
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(posedge clock);
        @(negedge clock);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 3'($urandom);
    endtask

    task automatic issue(input logic wr, input logic [4:0] addr, input logic [2:0] wd);
        int cyc;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("accept", bus.req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_acc(input logic wr, input logic [4:0] addr, input logic [2:0] wd);
        int         hw, vw;
        logic [1:0] si;
        logic [2:0] exp_rd;
        si = addr[1:0];
        hw = lookup(addr);
        issue(wr, addr, wd);
        if (hw >= 0) begin
            exp_rd = wr ? wd : mdat[si][hw];
            chk("hit_vld", bus.resp_valid, 1);
            chk("hit_flag", bus.resp_hit, 1);
            chk("hit_rdata", bus.resp_rdata, exp_rd);
            chk("hit_nomem", bus.mem_req, 0);
            if (wr) begin
                mdat[si][hw] = wd;
                md[si][hw]   = 1'b1;
            end
            touch(si, hw);
            m_hits++;
        end else begin
            vw = -1;
            for (int w = 0; w < 4; w++) if (vw < 0 && !mv[si][w]) vw = w;
            if (vw < 0) vw = ord[si][ord[si].size() - 1];
            if (mv[si][vw] && md[si][vw]) begin
                chk("wb_req", bus.mem_req, 1);
                chk("wb_we", bus.mem_we, 1);
                chk("wb_addr", bus.mem_addr, {mt[si][vw], si});
                chk("wb_data", bus.mem_wdata, mdat[si][vw]);
                last_wb_addr = bus.mem_addr;
                last_wb_dat  = bus.mem_wdata;
                serve(3'($urandom));
                mem[{mt[si][vw], si}] = mdat[si][vw];
            end
            chk("rf_req", bus.mem_req, 1);
            chk("rf_we", bus.mem_we, 0);
            chk("rf_addr", bus.mem_addr, addr);
            serve(mem[addr]);
            exp_rd = wr ? wd : mem[addr];
            chk("miss_vld", bus.resp_valid, 1);
            chk("miss_flag", bus.resp_hit, 0);
            chk("miss_rdata", bus.resp_rdata, exp_rd);
            mv[si][vw]   = 1'b1;
            md[si][vw]   = wr;
            mt[si][vw]   = addr[4:2];
            mdat[si][vw] = exp_rd;
            touch(si, vw);
            m_miss++;
        end
        @(negedge clock);
        chk("resp_pulse", bus.resp_valid, 0);
        chk("ready_again", bus.req_ready, 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rvld", bus.resp_valid, 0);
        chk("rst_rhit", bus.resp_hit, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_mreq", bus.mem_req, 0);
        chk("rst_mwe", bus.mem_we, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_mwdata", bus.mem_wdata, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         pick;
        logic [4:0] a;
        n_chk = 0;
        n_err = 0;
        m_hits = 0;
        m_miss = 0;
        last_wb_addr = '0;
        last_wb_dat  = '0;
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = 3'($urandom);
        mem[2] = 3'b101;
        model_reset();

        repeat (3) @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", bus.req_ready, 0);
        @(negedge clock);
        chk("ready_after_rel", bus.req_ready, 1);

        // Read miss then hit on 00010, write-allocate 00110, fill set 2, LRU eviction of dirty tag 1.
        do_acc(1'b0, 5'b00010, 3'b000);
        do_acc(1'b0, 5'b00010, 3'b000);
        do_acc(1'b1, 5'b00110, 3'b011);
        do_acc(1'b0, 5'b00110, 3'b000);
        do_acc(1'b0, 5'b01010, 3'b000);
        do_acc(1'b0, 5'b01110, 3'b000);
        do_acc(1'b0, 5'b00010, 3'b000);
        do_acc(1'b0, 5'b10010, 3'b000);
        chk("evict_addr", last_wb_addr, 5'b00110);
        chk("evict_data", last_wb_dat, 3'b011);
        do_acc(1'b0, 5'b00110, 3'b000);

        for (int i = 0; i < 300; i++) begin
            do_acc(1'($urandom), 5'($urandom), 3'($urandom));
        end

`ifdef CACHE_STATS_EN
        chk("stat_hits", hit_count, m_hits);
        chk("stat_miss", miss_count, m_miss);
`endif

        // Reset in the middle of a refill: the request is dropped and the cache comes back empty.
        pick = -1;
        for (int i = 0; i < 32; i++) if (pick < 0 && lookup(5'(i)) < 0) pick = i;
        a = 5'(pick);
        issue(1'b0, a, 3'b000);
        chk("mid_mreq", bus.mem_req, 1);
        if (bus.mem_we) begin
            serve(3'($urandom));
            mem[bus.mem_addr] = mem[bus.mem_addr];
        end
        chk("mid_refill", bus.mem_we, 0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_mreq_drop", bus.mem_req, 0);
        chk("mid_ready_low", bus.req_ready, 0);
        @(negedge clock);
        check_reset_outputs();
`ifdef CACHE_STATS_EN
        chk("stat_hits_rst", hit_count, 0);
        chk("stat_miss_rst", miss_count, 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        for (int i = 0; i < 4; i++) do_acc(1'b0, 5'b00010 + 5'(i), 3'b000);
        for (int i = 0; i < 40; i++) do_acc(1'($urandom), 5'($urandom), 3'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
